// File: rtl/digit_lock_ctrl_if.sv
// ============================================================================
// digit_lock_ctrl_if : keypad inputs and status/strobe outputs of the lock | Rev 1.0
// ============================================================================
`default_nettype none

interface digit_lock_ctrl_if #(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4
);
  localparam int C_IDX_W = $clog2(DIGITS);

  logic                      enter;
  logic [DIGIT_W-1:0]        digit_in;
  logic                      clear_entry;
  logic                      change_req;
  logic                      lock_cmd;
  logic [2:0]                state;
  logic [C_IDX_W-1:0]        digit_idx;
  logic [DIGITS*DIGIT_W-1:0] entry_bus;
  logic [3:0]                fail_cnt;
  logic                      unlocked;
  logic                      lockout;
  logic                      ok_pulse;
  logic                      fail_pulse;
  logic                      changed_pulse;
  logic                      change_err_pulse;

  modport master (
    output enter, digit_in, clear_entry, change_req, lock_cmd,
    input  state, digit_idx, entry_bus, fail_cnt, unlocked, lockout,
           ok_pulse, fail_pulse, changed_pulse, change_err_pulse
  );

  modport slave (
    input  enter, digit_in, clear_entry, change_req, lock_cmd,
    output state, digit_idx, entry_bus, fail_cnt, unlocked, lockout,
           ok_pulse, fail_pulse, changed_pulse, change_err_pulse
  );
endinterface

`default_nettype wire

// File: rtl/digit_lock_ctrl.sv
// ============================================================================
// digit_lock_ctrl : digit-code lock with code change and failed-try lockout | Rev 1.0
// ============================================================================
`default_nettype none

module digit_lock_ctrl #(
  parameter int                        DIGITS       = 4,
  parameter int                        DIGIT_W      = 4,
  parameter int                        MAX_FAILS    = 3,
  parameter int                        LOCKOUT_CYC  = 1000,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = '0
) (
  input  logic             clk,
  input  logic             rst,
  digit_lock_ctrl_if.slave bus
);
  localparam int                c_idx_w      = $clog2(DIGITS);
  localparam int                c_code_w     = DIGITS * DIGIT_W;
  localparam int                c_lo_w       = $clog2(LOCKOUT_CYC);
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(DIGITS - 1);
  localparam logic [c_lo_w-1:0]  c_lo_last   = c_lo_w'(LOCKOUT_CYC - 1);
  localparam logic [3:0]         c_fail_lim  = 4'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_LOCKED   = 3'd0,
    S_CHECK    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_CHANGE   = 3'd3,
    S_CONFIRM  = 3'd4,
    S_LOCKOUT  = 3'd5
  } state_t;

  state_t              r_state;
  logic [c_code_w-1:0] r_entry;
  logic [c_code_w-1:0] r_shadow;
  logic [c_code_w-1:0] r_code;
  logic [c_idx_w-1:0]  r_idx;
  logic [3:0]          r_fails;
  logic [c_lo_w-1:0]   r_lo_cnt;
  logic                r_ok;
  logic                r_fail;
  logic                r_changed;
  logic                r_change_err;

  logic [c_code_w-1:0] w_cap;
  logic [3:0]          w_fail_inc;

  // Buffer as it will look once the current digit is captured.
  always_comb begin
    w_cap = r_entry;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == c_idx_w'(k)) begin
        w_cap[k*DIGIT_W +: DIGIT_W] = bus.digit_in;
      end
    end
  end

  assign w_fail_inc = (r_fails == 4'hF) ? 4'hF : r_fails + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_LOCKED;
      r_entry      <= '0;
      r_shadow     <= '0;
      r_code       <= DEFAULT_CODE;
      r_idx        <= '0;
      r_fails      <= '0;
      r_lo_cnt     <= '0;
      r_ok         <= 1'b0;
      r_fail       <= 1'b0;
      r_changed    <= 1'b0;
      r_change_err <= 1'b0;
    end else begin
      r_ok         <= 1'b0;
      r_fail       <= 1'b0;
      r_changed    <= 1'b0;
      r_change_err <= 1'b0;
      case (r_state)
        S_CHECK: begin
          r_entry <= '0;
          if (r_entry == r_code) begin
            r_state <= S_UNLOCKED;
            r_fails <= '0;
            r_ok    <= 1'b1;
          end else begin
            r_fails <= w_fail_inc;
            r_fail  <= 1'b1;
            r_state <= (w_fail_inc == c_fail_lim) ? S_LOCKOUT : S_LOCKED;
          end
        end
        S_LOCKOUT: begin
          if (r_lo_cnt == c_lo_last) begin
            r_lo_cnt <= '0;
            r_fails  <= '0;
            r_state  <= S_LOCKED;
          end else begin
            r_lo_cnt <= r_lo_cnt + 1'b1;
          end
        end
        S_LOCKED, S_UNLOCKED, S_CHANGE, S_CONFIRM: begin
          // Commands beat clear, and clear beats a digit on the same edge.
          if (r_state == S_UNLOCKED && (bus.lock_cmd || bus.change_req)) begin
            r_entry <= '0;
            r_idx   <= '0;
            r_state <= bus.lock_cmd ? S_LOCKED : S_CHANGE;
          end else if (bus.clear_entry) begin
            r_entry <= '0;
            r_idx   <= '0;
          end else if (bus.enter) begin
            if (r_idx != c_last_idx) begin
              r_entry <= w_cap;
              r_idx   <= r_idx + 1'b1;
            end else begin
              r_idx   <= '0;
              r_entry <= '0;
              case (r_state)
                S_LOCKED: begin
                  r_entry <= w_cap;
                  r_state <= S_CHECK;
                end
                S_UNLOCKED: begin
                  if (w_cap == r_code) begin
                    r_state <= S_LOCKED;
                    r_ok    <= 1'b1;
                  end else begin
                    r_fail  <= 1'b1;
                  end
                end
                S_CHANGE: begin
                  r_shadow <= w_cap;
                  r_state  <= S_CONFIRM;
                end
                default: begin
                  if (w_cap == r_shadow) begin
                    r_code    <= r_shadow;
                    r_changed <= 1'b1;
                    r_state   <= S_LOCKED;
                  end else begin
                    r_change_err <= 1'b1;
                    r_state      <= S_UNLOCKED;
                  end
                end
              endcase
            end
          end
        end
        default: r_state <= S_LOCKED;
      endcase
    end
  end

  assign bus.state            = r_state;
  assign bus.digit_idx        = r_idx;
  assign bus.entry_bus        = r_entry;
  assign bus.fail_cnt         = r_fails;
  assign bus.unlocked         = (r_state == S_UNLOCKED) || (r_state == S_CHANGE) ||
                                (r_state == S_CONFIRM);
  assign bus.lockout          = (r_state == S_LOCKOUT);
  assign bus.ok_pulse         = r_ok;
  assign bus.fail_pulse       = r_fail;
  assign bus.changed_pulse    = r_changed;
  assign bus.change_err_pulse = r_change_err;

endmodule

`default_nettype wire

// File: doc/digit_lock_ctrl.md
DIGIT_LOCK_CTRL -- requirements
Module: digit_lock_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: code length in digits, range 2..8.
REQ-002 Parameter DIGIT_W, default 4: width of one digit in bits.
REQ-003 Parameter MAX_FAILS, default 3: number of consecutive wrong codes that triggers lockout, range 1..15.
REQ-004 Parameter LOCKOUT_CYC, default 1000: lockout duration in clk cycles, at least 2.
REQ-005 Parameter DEFAULT_CODE, default 0: code loaded at reset, width DIGITS*DIGIT_W.
REQ-006 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-007 Port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-008 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-009 Port enter, input, 1 bit: debounced single-cycle pulse that captures digit_in.
REQ-010 Port digit_in, input, DIGIT_W bits: digit value from the switches.
REQ-011 Port clear_entry, input, 1 bit: pulse that discards the digits entered so far.
REQ-012 Port change_req, input, 1 bit: pulse that requests a code change; honoured only in UNLOCKED.
REQ-013 Port lock_cmd, input, 1 bit: pulse that re-locks; honoured only in UNLOCKED.
REQ-014 Port state, output, 3 bits: LOCKED=0, CHECK=1, UNLOCKED=2, CHANGE=3, CONFIRM=4, LOCKOUT=5.
REQ-015 Port digit_idx, output, $clog2(DIGITS) bits: index of the next digit to capture.
REQ-016 Port entry_bus, output, DIGITS*DIGIT_W bits: entry buffer for display; digit k is at [k*DIGIT_W +: DIGIT_W], first digit at the LSB.
REQ-017 Port fail_cnt, output, 4 bits: consecutive wrong-code count.
REQ-018 Port unlocked, output, 1 bit: high while state is UNLOCKED, CHANGE or CONFIRM.
REQ-019 Port lockout, output, 1 bit: high while state is LOCKOUT.
REQ-020 Ports ok_pulse, fail_pulse, changed_pulse, change_err_pulse, output, 1 bit each: single-cycle event strobes.

Function
REQ-021 Digit capture: an enter sampled at edge t writes digit_in into buffer[digit_idx] and increments digit_idx; both are visible after edge t.
REQ-022 Capture applies in LOCKED, UNLOCKED, CHANGE and CONFIRM; enter is ignored in CHECK and LOCKOUT.
REQ-023 The enter that captures digit DIGITS-1 sets digit_idx to 0; the next state on that same edge depends on the current state:
  - LOCKED -> CHECK.
  - UNLOCKED -> compare immediately.
  - CHANGE -> CONFIRM.
  - CONFIRM -> compare immediately.
REQ-024 CHECK lasts exactly one cycle; the comparison uses the complete buffer including the last digit.
REQ-025 CHECK on a match:
  - next state UNLOCKED;
  - fail_cnt cleared to 0;
  - ok_pulse high for the one cycle after the transition edge.
REQ-026 CHECK on a mismatch:
  - fail_cnt incremented, saturating at 15;
  - fail_pulse high for one cycle;
  - next state LOCKOUT if the new fail_cnt equals MAX_FAILS, otherwise LOCKED.
REQ-027 LOCKOUT: an internal counter runs from 0 to LOCKOUT_CYC-1, then the state returns to LOCKED with fail_cnt=0; all inputs are ignored during LOCKOUT.
REQ-028 UNLOCKED, on completion of a full code entry:
  - match -> LOCKED with ok_pulse;
  - mismatch -> stays UNLOCKED with fail_pulse;
  - fail_cnt is not changed in either case.
REQ-029 UNLOCKED, lock_cmd -> LOCKED with the buffer and digit_idx cleared.
REQ-030 UNLOCKED, change_req -> CHANGE with the buffer and digit_idx cleared.
REQ-031 CONFIRM holds the first entry in a shadow register and collects a second entry.
REQ-032 CONFIRM, entries equal:
  - stored code := shadow;
  - changed_pulse high for one cycle;
  - next state LOCKED.
REQ-033 CONFIRM, entries differ:
  - stored code unchanged;
  - change_err_pulse high for one cycle;
  - next state UNLOCKED.
REQ-034 clear_entry sets digit_idx and the buffer to 0 and does not change state; in CONFIRM, the shadow is retained.
REQ-035 Simultaneous events on one edge:
  - clear_entry and enter: clear wins, the digit is discarded.
  - lock_cmd and change_req: lock wins.
  - lock_cmd or change_req together with enter in UNLOCKED: the command wins, the digit is discarded.
REQ-036 At most one event strobe is high in any cycle; strobes are registered outputs.
REQ-037 The entry buffer is cleared on every transition into LOCKED, UNLOCKED, CHANGE or LOCKOUT; the transition into CONFIRM also clears the buffer, after the first entry has been copied to the shadow.

Reset
REQ-038 While rst=0, asynchronously:
  - state=LOCKED;
  - stored code := DEFAULT_CODE;
  - buffer, shadow, digit_idx, fail_cnt and the lockout counter = 0;
  - all strobes = 0; unlocked = 0; lockout = 0.
REQ-039 Reset asserted mid-entry, in CHANGE/CONFIRM or in LOCKOUT aborts the operation with no partial write to the stored code.
REQ-040 The first capture can occur on the first rising edge after rst deasserts.

Verification
Bench parameters: DIGITS=4, DIGIT_W=4, MAX_FAILS=3, LOCKOUT_CYC=16, DEFAULT_CODE=0.
REQ-041 Scenario, correct code: reset, enter 0,0,0,0 -> CHECK for 1 cycle, then UNLOCKED, ok_pulse for 1 cycle, unlocked=1, fail_cnt=0.
REQ-042 Scenario, change code: from UNLOCKED, change_req, enter 1,2,3,4, then 1,2,3,4 -> changed_pulse, LOCKED. Entering 0,0,0,0 then gives fail_pulse; entering 1,2,3,4 gives UNLOCKED.
REQ-043 Scenario, confirm mismatch: change_req, enter 5,5,5,5, then 5,5,5,6 -> change_err_pulse, UNLOCKED, stored code unchanged.
REQ-044 Scenario, lockout: three wrong codes -> fail_cnt 1, 2, 3; lockout=1 for exactly 16 cycles with enter pulses ignored; then LOCKED, fail_cnt=0.
REQ-045 Scenario, clear priority: enter 7,7, then clear_entry and enter in the same cycle -> digit_idx=0, entry_bus=0, state LOCKED.
REQ-046 Scenario, reset mid-change: change_req, enter 9,9, reset -> LOCKED, and entering 0,0,0,0 unlocks.
